// File: rtl/exec_bus_core_pkg.sv
// rtl/exec_bus_core_pkg.sv - shared bus codes, carry-select codes and carry-in helper
package exec_bus_core_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    // Main-bus driver/receiver codes; 8..15 are unused and decode to nothing
    typedef enum logic [3:0] {
        BUS_NONE  = 4'd0,
        BUS_A     = 4'd1,
        BUS_B     = 4'd2,
        BUS_CONST = 4'd3,
        BUS_ALU   = 4'd4,
        BUS_MEM   = 4'd5,
        BUS_TL    = 4'd6,
        BUS_TH    = 4'd7
    } main_code_e;

    // Operand bus (LHS/RHS) driver codes
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_A    = 2'd1,
        OP_B    = 2'd2,
        OP_RSVD = 2'd3
    } op_code_e;

    // Adder carry-in source
    typedef enum logic [1:0] {
        CS_ZERO  = 2'd0,
        CS_ONE   = 2'd1,
        CS_CARRY = 2'd2,
        CS_RSVD  = 2'd3
    } carry_sel_e;

    // Reserved select behaves like zero so an unused encoding cannot inject a carry
    function automatic logic carry_in_sel(input logic [1:0] cs, input logic carry);
        case (cs)
            CS_ONE:   return 1'b1;
            CS_CARRY: return carry;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_bus_core_reset_sync.sv
// rtl/exec_bus_core_reset_sync.sv - two-flop reset conditioner, async assert / sync deassert
module exec_bus_core_reset_sync (
    input  logic clk,
    input  logic reset_in_n,
    output logic reset_out_n
);

    logic [1:0] chain;

    // Clear immediately on reset; shift a 1 through so release lands on the 2nd edge
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            chain <= 2'b00;
        end else begin
            chain <= {chain[0], 1'b1};
        end
    end

    assign reset_out_n = chain[1];

endmodule

// File: rtl/exec_bus_core.sv
// rtl/exec_bus_core.sv - reset conditioner, bus-code decode and ALU adder of the execution core
module exec_bus_core
    import exec_bus_core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_in_n,
    output logic                  reset_out_n,
    input  logic [3:0]            MainAssert,
    input  logic [3:0]            MainLoad,
    input  logic [1:0]            LhsAssert,
    input  logic [1:0]            RhsAssert,
    output logic                  reg_A_load,
    output logic                  reg_A_assert,
    output logic                  reg_A_LHS,
    output logic                  reg_A_RHS,
    output logic                  reg_B_load,
    output logic                  reg_B_assert,
    output logic                  reg_B_LHS,
    output logic                  reg_B_RHS,
    output logic                  reg_Const_load,
    output logic                  reg_Const_assert,
    output logic                  reg_TL_load,
    output logic                  reg_TL_assert,
    output logic                  reg_TH_load,
    output logic                  reg_TH_assert,
    output logic                  alu_assert,
    output logic                  memBridge_load,
    output logic                  memBridge_direction,
    input  logic                  carryIn,
    input  logic [1:0]            CarrySelect,
    input  logic [DATA_WIDTH-1:0] Lhs,
    input  logic [DATA_WIDTH-1:0] Rhs,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carryOut,
    output logic [DATA_WIDTH-1:0] mainBusOut
);

    logic              cin;
    logic [DATA_WIDTH:0] sum;

    exec_bus_core_reset_sync u_reset_sync (
        .clk         (clk),
        .reset_in_n  (reset_in_n),
        .reset_out_n (reset_out_n)
    );

    // Decode the three buses independently; everything is held low while in reset
    always_comb begin
        reg_A_load          = 1'b0;
        reg_A_assert        = 1'b0;
        reg_A_LHS           = 1'b0;
        reg_A_RHS           = 1'b0;
        reg_B_load          = 1'b0;
        reg_B_assert        = 1'b0;
        reg_B_LHS           = 1'b0;
        reg_B_RHS           = 1'b0;
        reg_Const_load      = 1'b0;
        reg_Const_assert    = 1'b0;
        reg_TL_load         = 1'b0;
        reg_TL_assert       = 1'b0;
        reg_TH_load         = 1'b0;
        reg_TH_assert       = 1'b0;
        alu_assert          = 1'b0;
        memBridge_load      = 1'b0;
        memBridge_direction = 1'b0;
        if (reset_out_n) begin
            case (MainAssert)
                BUS_A:     reg_A_assert        = 1'b1;
                BUS_B:     reg_B_assert        = 1'b1;
                BUS_CONST: reg_Const_assert    = 1'b1;
                BUS_ALU:   alu_assert          = 1'b1;
                BUS_MEM:   memBridge_direction = 1'b1;
                BUS_TL:    reg_TL_assert       = 1'b1;
                BUS_TH:    reg_TH_assert       = 1'b1;
                default:   ;
            endcase
            case (MainLoad)
                BUS_A:     reg_A_load     = 1'b1;
                BUS_B:     reg_B_load     = 1'b1;
                BUS_CONST: reg_Const_load = 1'b1;
                // Memory cannot be both source and sink of the same bus cycle
                BUS_MEM:   memBridge_load = (MainAssert != BUS_MEM);
                BUS_TL:    reg_TL_load    = 1'b1;
                BUS_TH:    reg_TH_load    = 1'b1;
                default:   ;
            endcase
            case (LhsAssert)
                OP_A:    reg_A_LHS = 1'b1;
                OP_B:    reg_B_LHS = 1'b1;
                default: ;
            endcase
            case (RhsAssert)
                OP_A:    reg_A_RHS = 1'b1;
                OP_B:    reg_B_RHS = 1'b1;
                default: ;
            endcase
        end
    end

    // Adder runs regardless of reset; one extra bit captures the carry out
    always_comb begin
        cin = carry_in_sel(CarrySelect, carryIn);
        sum = {1'b0, Lhs} + {1'b0, Rhs} + {{DATA_WIDTH{1'b0}}, cin};
    end

    assign result     = sum[DATA_WIDTH-1:0];
    assign carryOut   = sum[DATA_WIDTH];
    assign mainBusOut = alu_assert ? result : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_exec_bus_core.sv
// tb/tb_exec_bus_core.sv - scoreboard bench for exec_bus_core with directed vectors
module tb_exec_bus_core;

    localparam int W = 16;

    localparam logic [16:0] S_A_LD   = 17'd1 << 0;
    localparam logic [16:0] S_A_AS   = 17'd1 << 1;
    localparam logic [16:0] S_A_LHS  = 17'd1 << 2;
    localparam logic [16:0] S_A_RHS  = 17'd1 << 3;
    localparam logic [16:0] S_B_LD   = 17'd1 << 4;
    localparam logic [16:0] S_B_AS   = 17'd1 << 5;
    localparam logic [16:0] S_B_LHS  = 17'd1 << 6;
    localparam logic [16:0] S_B_RHS  = 17'd1 << 7;
    localparam logic [16:0] S_C_LD   = 17'd1 << 8;
    localparam logic [16:0] S_C_AS   = 17'd1 << 9;
    localparam logic [16:0] S_TL_LD  = 17'd1 << 10;
    localparam logic [16:0] S_TL_AS  = 17'd1 << 11;
    localparam logic [16:0] S_TH_LD  = 17'd1 << 12;
    localparam logic [16:0] S_TH_AS  = 17'd1 << 13;
    localparam logic [16:0] S_ALU    = 17'd1 << 14;
    localparam logic [16:0] S_MEM_LD = 17'd1 << 15;
    localparam logic [16:0] S_MEM_DR = 17'd1 << 16;

    typedef struct {
        string       name;
        logic        rst;
        logic [16:0] str;
        logic [W-1:0] res;
        logic        co;
        logic [W-1:0] bus;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_in_n;
    logic         reset_out_n;
    logic [3:0]   MainAssert, MainLoad;
    logic [1:0]   LhsAssert, RhsAssert, CarrySelect;
    logic         carryIn;
    logic [W-1:0] Lhs, Rhs, result, mainBusOut;
    logic         carryOut;
    logic         reg_A_load, reg_A_assert, reg_A_LHS, reg_A_RHS;
    logic         reg_B_load, reg_B_assert, reg_B_LHS, reg_B_RHS;
    logic         reg_Const_load, reg_Const_assert;
    logic         reg_TL_load, reg_TL_assert, reg_TH_load, reg_TH_assert;
    logic         alu_assert, memBridge_load, memBridge_direction;
    logic [16:0]  act_str;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    exec_bus_core #(.DATA_WIDTH(W)) dut (
        .clk                 (clk),
        .reset_in_n          (reset_in_n),
        .reset_out_n         (reset_out_n),
        .MainAssert          (MainAssert),
        .MainLoad            (MainLoad),
        .LhsAssert           (LhsAssert),
        .RhsAssert           (RhsAssert),
        .reg_A_load          (reg_A_load),
        .reg_A_assert        (reg_A_assert),
        .reg_A_LHS           (reg_A_LHS),
        .reg_A_RHS           (reg_A_RHS),
        .reg_B_load          (reg_B_load),
        .reg_B_assert        (reg_B_assert),
        .reg_B_LHS           (reg_B_LHS),
        .reg_B_RHS           (reg_B_RHS),
        .reg_Const_load      (reg_Const_load),
        .reg_Const_assert    (reg_Const_assert),
        .reg_TL_load         (reg_TL_load),
        .reg_TL_assert       (reg_TL_assert),
        .reg_TH_load         (reg_TH_load),
        .reg_TH_assert       (reg_TH_assert),
        .alu_assert          (alu_assert),
        .memBridge_load      (memBridge_load),
        .memBridge_direction (memBridge_direction),
        .carryIn             (carryIn),
        .CarrySelect         (CarrySelect),
        .Lhs                 (Lhs),
        .Rhs                 (Rhs),
        .result              (result),
        .carryOut            (carryOut),
        .mainBusOut          (mainBusOut)
    );

    assign act_str = {memBridge_direction, memBridge_load, alu_assert,
                      reg_TH_assert, reg_TH_load, reg_TL_assert, reg_TL_load,
                      reg_Const_assert, reg_Const_load,
                      reg_B_RHS, reg_B_LHS, reg_B_assert, reg_B_load,
                      reg_A_RHS, reg_A_LHS, reg_A_assert, reg_A_load};

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "reset_out_n", {31'd0, reset_out_n}, {31'd0, e.rst});
            check(e.name, "strobes", {15'd0, act_str}, {15'd0, e.str});
            check(e.name, "result", {16'd0, result}, {16'd0, e.res});
            check(e.name, "carryOut", {31'd0, carryOut}, {31'd0, e.co});
            check(e.name, "mainBusOut", {16'd0, mainBusOut}, {16'd0, e.bus});
        end
    end

    task automatic vec(input string name, input logic rst,
                       input logic [3:0] ma, input logic [3:0] ml,
                       input logic [1:0] la, input logic [1:0] ra,
                       input logic [1:0] cs, input logic ci,
                       input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic e_rst, input logic [16:0] e_str,
                       input logic [W-1:0] e_res, input logic e_co,
                       input logic [W-1:0] e_bus);
        exp_t e;
        @(posedge clk);
        #1;
        reset_in_n  = rst;
        MainAssert  = ma;
        MainLoad    = ml;
        LhsAssert   = la;
        RhsAssert   = ra;
        CarrySelect = cs;
        carryIn     = ci;
        Lhs         = l;
        Rhs         = r;
        e.name = name; e.rst = e_rst; e.str = e_str;
        e.res = e_res; e.co = e_co; e.bus = e_bus;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_in_n = 1'b0; MainAssert = 4'd1; MainLoad = 4'd0;
        LhsAssert = 2'd0; RhsAssert = 2'd0; CarrySelect = 2'd0;
        carryIn = 1'b0; Lhs = '0; Rhs = '0;

        //  name         rst ma  ml  la ra cs ci Lhs       Rhs       ersr estr               eres      eco ebus
        vec("rst_hold",  0, 1,  0,  0, 0, 0, 0, 16'h00FF, 16'h0001, 0, 17'd0,             16'h0100, 0, 16'h0000);
        vec("rel_e0",    1, 1,  0,  0, 0, 0, 0, 16'h00FF, 16'h0001, 0, 17'd0,             16'h0100, 0, 16'h0000);
        vec("rel_e1",    1, 1,  0,  0, 0, 0, 0, 16'h00FF, 16'h0001, 0, 17'd0,             16'h0100, 0, 16'h0000);
        vec("rel_e2",    1, 1,  0,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_A_AS,            16'h0100, 0, 16'h0000);
        vec("a_to_b",    1, 1,  2,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_A_AS|S_B_LD,     16'h0100, 0, 16'h0000);
        vec("ma9",       1, 9,  0,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0100, 0, 16'h0000);
        vec("mem_rd",    1, 5,  1,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_MEM_DR|S_A_LD,   16'h0100, 0, 16'h0000);
        vec("mem_wr",    1, 1,  5,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_A_AS|S_MEM_LD,   16'h0100, 0, 16'h0000);
        vec("mem_mem",   1, 5,  5,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_MEM_DR,          16'h0100, 0, 16'h0000);
        vec("ops_ab",    1, 0,  0,  1, 2, 0, 0, 16'h00FF, 16'h0001, 1, S_A_LHS|S_B_RHS,   16'h0100, 0, 16'h0000);
        vec("ops_ba",    1, 0,  0,  2, 1, 0, 0, 16'h00FF, 16'h0001, 1, S_B_LHS|S_A_RHS,   16'h0100, 0, 16'h0000);
        vec("ops_rsvd",  1, 0,  0,  3, 3, 0, 0, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0100, 0, 16'h0000);
        vec("const",     1, 3,  3,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_C_AS|S_C_LD,     16'h0100, 0, 16'h0000);
        vec("tl_th",     1, 6,  7,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_TL_AS|S_TH_LD,   16'h0100, 0, 16'h0000);
        vec("th_tl",     1, 7,  6,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_TH_AS|S_TL_LD,   16'h0100, 0, 16'h0000);
        vec("ld4",       1, 2,  4,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_B_AS,            16'h0100, 0, 16'h0000);
        vec("a_to_a",    1, 1,  1,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, S_A_AS|S_A_LD,     16'h0100, 0, 16'h0000);
        vec("ld15",      1, 0, 15,  0, 0, 0, 0, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0100, 0, 16'h0000);
        vec("cs0",       1, 0,  0,  0, 0, 0, 1, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0100, 0, 16'h0000);
        vec("cs1",       1, 0,  0,  0, 0, 1, 0, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0101, 0, 16'h0000);
        vec("cs2_c1",    1, 0,  0,  0, 0, 2, 1, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0101, 0, 16'h0000);
        vec("cs2_c0",    1, 0,  0,  0, 0, 2, 0, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0100, 0, 16'h0000);
        vec("cs3",       1, 0,  0,  0, 0, 3, 1, 16'h00FF, 16'h0001, 1, 17'd0,             16'h0100, 0, 16'h0000);
        vec("wrap_alu",  1, 4,  0,  0, 0, 1, 0, 16'hFFFF, 16'h0001, 1, S_ALU,             16'h0001, 1, 16'h0001);
        vec("wrap_noas", 1, 0,  0,  0, 0, 1, 0, 16'hFFFF, 16'h0001, 1, 17'd0,             16'h0001, 1, 16'h0000);
        vec("max_sum",   1, 4,  2,  0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 1, S_ALU|S_B_LD,      16'hFFFF, 1, 16'hFFFF);
        vec("mid_rst",   0, 4,  1,  1, 2, 1, 0, 16'hFFFF, 16'h0001, 0, 17'd0,             16'h0001, 1, 16'h0000);
        vec("mid_e0",    1, 4,  1,  1, 2, 0, 0, 16'h1234, 16'h4321, 0, 17'd0,             16'h5555, 0, 16'h0000);
        vec("mid_e1",    1, 4,  1,  1, 2, 0, 0, 16'h1234, 16'h4321, 0, 17'd0,             16'h5555, 0, 16'h0000);
        vec("mid_e2",    1, 4,  1,  1, 2, 0, 0, 16'h1234, 16'h4321, 1, S_ALU|S_A_LD|S_A_LHS|S_B_RHS, 16'h5555, 0, 16'h5555);

        begin : drain
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_bad++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
